// File: rtl/pwm_capture.sv
// pwm_capture: input-capture peripheral measuring period and high time of pwm_i in prescaled ticks
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        re_i,
  input  logic        we_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic [31:0] rdata_o,
  input  logic        pwm_i,
  output logic        irq_o,
  output logic        active_o
);
  localparam logic [2:0] IDLE = 3'd0, ARM = 3'd1, HIGH = 3'd2, LOW = 3'd3, DONE = 3'd4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  logic [SYNC_STAGES-1:0] sync_q;
  logic lvl_q, rise_q, fall_q, lvl, rise, fall;
  logic [3:0] ctrl_q, ctrl_d;
  logic soft_q, soft_d, irq_q, irq_d;
  logic [CNT_W-1:0] div_q, div_d, pre_q, pre_d, per_cnt_q, per_cnt_d, hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] period_q, period_d, high_q, high_d, snap_q, snap_d, tick_w;
  logic [2:0] status_q, status_d, set, state_q, state_d;
  logic wr, wr_ctrl, wr_div, wr_stat, rd_per, en, tick, sat, unused_ok;
  logic [31:0] mask, div_wr;

  assign wr = we_i & ~re_i;
  assign wr_ctrl = wr & (addr_i == 8'h00) & be_i[0];
  assign wr_div = wr & (addr_i == 8'h04) & |be_i;
  assign wr_stat = wr & (addr_i == 8'h10) & be_i[0];
  assign rd_per = re_i & (addr_i == 8'h08);
  assign mask = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
  assign div_wr = (32'(div_q) & ~mask) | (wdata_i & mask);
  assign unused_ok = ^{wdata_i, div_wr};
  assign en = ctrl_q[0];
  assign lvl = sync_q[SYNC_STAGES-1] ^ ctrl_q[3];
  assign rise = rise_q & en;
  assign fall = fall_q & en;
  assign tick = en & ((div_q <= CNT_W'(1)) | (pre_q == div_q - 1'b1));
  assign tick_w = CNT_W'(tick);
  assign sat = tick & (per_cnt_q == CNT_MAX - 1'b1);
  assign irq_o = irq_q;
  assign active_o = state_q != IDLE;

  // read mux; HIGH returns the snapshot taken on the last PERIOD read
  always_comb begin
    rdata_o = addr_i == 8'h00 ? {24'b0, soft_q, 3'b000, ctrl_q}
            : addr_i == 8'h04 ? 32'(div_q)
            : addr_i == 8'h08 ? 32'(period_q)
            : addr_i == 8'h0C ? 32'(snap_q)
            : addr_i == 8'h10 ? {29'b0, status_q}
            : 32'b0;
  end

  // next state: bus writes, prescaler, measurement FSM, status and interrupt
  always_comb begin
    ctrl_d = wr_ctrl ? wdata_i[3:0] : ctrl_q;
    soft_d = wr_ctrl & wdata_i[7];
    div_d = wr_div ? div_wr[CNT_W-1:0] : div_q;
    pre_d = (!en || wr_div || tick) ? '0 : pre_q + 1'b1;
    snap_d = rd_per ? high_q : snap_q;
    period_d = period_q;
    high_d = high_q;
    per_cnt_d = per_cnt_q;
    hi_cnt_d = hi_cnt_q;
    state_d = state_q;
    set = 3'b000;
    case (state_q)
      IDLE: state_d = ARM;
      ARM: begin
        per_cnt_d = rise ? tick_w : per_cnt_q;
        hi_cnt_d = rise ? tick_w : hi_cnt_q;
        state_d = rise ? HIGH : ARM;
      end
      HIGH: begin
        per_cnt_d = per_cnt_q + tick_w;
        hi_cnt_d = fall ? hi_cnt_q : hi_cnt_q + tick_w;
        state_d = fall ? LOW : HIGH;
      end
      LOW: begin
        per_cnt_d = per_cnt_q + tick_w;
        if (rise) begin
          period_d = per_cnt_q;
          high_d = hi_cnt_q;
          set = {status_q[0], 2'b01};
          per_cnt_d = ctrl_q[1] ? tick_w : '0;
          hi_cnt_d = ctrl_q[1] ? tick_w : '0;
          state_d = ctrl_q[1] ? HIGH : DONE;
        end
      end
      DONE: state_d = (wr_ctrl && wdata_i[1:0] == 2'b11) ? ARM : DONE;
      default: state_d = IDLE;
    endcase
    if (sat && (state_q == HIGH || (state_q == LOW && !rise))) begin
      set[1] = 1'b1;
      per_cnt_d = '0;
      hi_cnt_d = '0;
      state_d = ARM;
    end
    if (!en) begin
      state_d = IDLE;
      per_cnt_d = '0;
      hi_cnt_d = '0;
    end
    status_d = (status_q & ~(wr_stat ? wdata_i[2:0] : 3'b000)) | set;
    irq_d = ctrl_q[2] & |status_q;
    if (soft_q) begin
      ctrl_d = '0;
      soft_d = 1'b0;
      div_d = '0;
      pre_d = '0;
      snap_d = '0;
      period_d = '0;
      high_d = '0;
      per_cnt_d = '0;
      hi_cnt_d = '0;
      state_d = IDLE;
      status_d = '0;
      irq_d = 1'b0;
    end
  end

  // synchroniser and edge flops; soft clear leaves them alone so it never fakes an edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      lvl_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
      lvl_q <= lvl;
      rise_q <= lvl & ~lvl_q;
      fall_q <= ~lvl & lvl_q;
    end
  end

  // register file, counters and FSM state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q <= '0;
      soft_q <= 1'b0;
      div_q <= '0;
      pre_q <= '0;
      snap_q <= '0;
      period_q <= '0;
      high_q <= '0;
      per_cnt_q <= '0;
      hi_cnt_q <= '0;
      state_q <= IDLE;
      status_q <= '0;
      irq_q <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      soft_q <= soft_d;
      div_q <= div_d;
      pre_q <= pre_d;
      snap_q <= snap_d;
      period_q <= period_d;
      high_q <= high_d;
      per_cnt_q <= per_cnt_d;
      hi_cnt_q <= hi_cnt_d;
      state_q <= state_d;
      status_q <= status_d;
      irq_q <= irq_d;
    end
  end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: randomized directed checks of pwm_capture against a tick-count reference model
module tb_pwm_capture;
  logic clk_i = 1'b0, rst_ni = 1'b0, re_i = 1'b0, we_i = 1'b0, pwm_i = 1'b0;
  logic [7:0] addr_i = 8'h00;
  logic [31:0] wdata_i = '0;
  logic [3:0] be_i = 4'h0;
  logic [31:0] rdata_o;
  logic irq_o, active_o;
  int total = 0, bad = 0;
  int p, h, p2, h2, dv, k;
  logic inv;
  logic [31:0] d;
  logic [7:0] regs [5] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10};

  pwm_capture dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .re_i(re_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .be_i(be_i), .rdata_o(rdata_o), .pwm_i(pwm_i),
    .irq_o(irq_o), .active_o(active_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] v);
    addr_i = a;
    wdata_i = v;
    be_i = 4'hF;
    we_i = 1'b1;
    @(negedge clk_i);
    we_i = 1'b0;
    be_i = 4'h0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] v);
    addr_i = a;
    re_i = 1'b1;
    #1 v = rdata_o;
    @(negedge clk_i);
    re_i = 1'b0;
  endtask

  // one physical PWM period: high for hi*div clocks, then low for (per-hi)*div clocks
  task automatic wave(input int per, input int hi, input int div);
    pwm_i = 1'b1;
    idle(hi * div);
    pwm_i = 1'b0;
    idle((per - hi) * div);
  endtask

  // reference: ticks a free-running prescaler delivers in a window of whole divisor periods
  function automatic int ticks(input int cycles, input int div);
    return cycles / (div > 1 ? div : 1);
  endfunction

  // reference: STATUS after a number of unacknowledged captures
  function automatic logic [31:0] exp_status(input int caps, input bit ovf);
    return {29'b0, caps > 1, ovf, caps > 0};
  endfunction

  // disable, program divisor and invert, clear status, settle pwm low, then enable
  task automatic setup(input logic [31:0] ctrl, input int div);
    wr(8'h00, ctrl & 32'h8);
    wr(8'h04, 32'(div));
    wr(8'h10, 32'h7);
    pwm_i = 1'b0;
    idle(5);
    wr(8'h00, ctrl);
    idle(3);
  endtask

  task automatic check_pair(input string tag, input int ep, input int eh);
    logic [31:0] v;
    rd(8'h08, v);
    chk({tag, "_period"}, v, 32'(ep));
    rd(8'h0C, v);
    chk({tag, "_high"}, v, 32'(eh));
  endtask

  initial begin
    idle(2);
    chk("rst_irq", {31'b0, irq_o}, 0);
    chk("rst_active", {31'b0, active_o}, 0);
    for (int i = 0; i < 5; i++) begin
      rd(regs[i], d);
      chk($sformatf("rst_reg%0h", regs[i]), d, 0);
    end
    rst_ni = 1'b1;
    idle(2);
    setup(32'h7, 1);
    chk("t1_active", {31'b0, active_o}, 1);
    wave(10, 3, 1);
    pwm_i = 1'b1;
    idle(6);
    check_pair("t1", ticks(10, 1), ticks(3, 1));
    rd(8'h10, d);
    chk("t1_status", d, exp_status(1, 0));
    chk("t1_irq", {31'b0, irq_o}, 1);
    wr(8'h10, 32'h1);
    idle(1);
    chk("t1_irq_clr", {31'b0, irq_o}, 0);
    for (int i = 0; i < 6; i++) begin
      dv = i == 0 ? 1 : int'($urandom_range(1, 4));
      p = i == 0 ? 10 : int'($urandom_range(5, 14));
      h = i == 0 ? 3 : int'($urandom_range(2, p - 2));
      inv = i == 0 ? 1'b1 : 1'($urandom_range(0, 1));
      setup(32'h7 | (inv ? 32'h8 : 32'h0), dv);
      wave(p, h, dv);
      if (inv) wave(p, h, dv);
      pwm_i = 1'b1;
      idle(6);
      check_pair($sformatf("rnd%0d_d%0d_p%0d_h%0d_i%0d", i, dv, p, h, inv),
                 ticks(p * dv, dv), ticks((inv ? p - h : h) * dv, dv));
      rd(8'h10, d);
      chk($sformatf("rnd%0d_status", i), d, exp_status(1, 0));
    end
    p = $urandom_range(5, 12);
    h = $urandom_range(2, p - 2);
    p2 = p + 3;
    h2 = $urandom_range(2, p2 - 2);
    setup(32'h7, 1);
    wave(p, h, 1);
    wave(p, h, 1);
    wave(p2, h2, 1);
    pwm_i = 1'b1;
    idle(6);
    check_pair("cont", p2, h2);
    rd(8'h10, d);
    chk("cont_overrun", d, exp_status(3, 0));
    wr(8'h10, 32'h4);
    rd(8'h10, d);
    chk("w1c_overrun_only", d, exp_status(1, 0));
    pwm_i = 1'b0;
    idle(5);
    pwm_i = 1'b1;
    idle(3);
    wr(8'h10, 32'h1);
    rd(8'h10, d);
    chk("w1c_vs_capture", d, exp_status(2, 0));
    setup(32'h5, 1);
    wave(p, h, 1);
    wave(p2, h2, 1);
    wave(p2, h2, 1);
    pwm_i = 1'b1;
    idle(6);
    check_pair("oneshot", p, h);
    rd(8'h10, d);
    chk("oneshot_status", d, exp_status(1, 0));
    chk("oneshot_active", {31'b0, active_o}, 1);
    wr(8'h00, 32'h7);
    pwm_i = 1'b0;
    idle(5);
    wave(p2, h2, 1);
    pwm_i = 1'b1;
    idle(6);
    check_pair("rearm", p2, h2);
    rd(8'h10, d);
    chk("rearm_status", d, exp_status(2, 0));
    setup(32'h7, 1);
    addr_i = 8'h10;
    pwm_i = 1'b1;
    k = 0;
    do begin
      @(negedge clk_i);
      k++;
    end while (!rdata_o[1] && k < 70000);
    chk("ovf_latency", 32'(k), 32'd65538);
    rd(8'h10, d);
    chk("ovf_status", d, exp_status(0, 1));
    chk("ovf_irq", {31'b0, irq_o}, 1);
    chk("ovf_active", {31'b0, active_o}, 1);
    wr(8'h10, 32'h2);
    rd(8'h10, d);
    chk("ovf_clr_status", d, 0);
    chk("ovf_clr_irq", {31'b0, irq_o}, 0);
    pwm_i = 1'b0;
    idle(5);
    wave(p, h, 1);
    pwm_i = 1'b1;
    idle(6);
    check_pair("after_ovf", p, h);
    setup(32'h7, 1);
    wave(p2, h2, 1);
    pwm_i = 1'b1;
    idle(6);
    chk("pre_rst_irq", {31'b0, irq_o}, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_irq", {31'b0, irq_o}, 0);
    chk("async_rst_active", {31'b0, active_o}, 0);
    for (int i = 0; i < 5; i++) begin
      addr_i = regs[i];
      #1 chk($sformatf("async_rst_reg%0h", regs[i]), rdata_o, 0);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle(2);
    setup(32'h7, 1);
    wave(p, h, 1);
    pwm_i = 1'b1;
    idle(6);
    check_pair("post_rst", p, h);
    rd(8'h10, d);
    chk("post_rst_status", d, exp_status(1, 0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
